// File: rtl/capture_dump_streamer_pkg.sv
// Shared definitions for the logic-analyser capture dump path.
package la_pkg;

    // Dump sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_READ,
        ST_LOAD,
        ST_SEND,
        ST_FIN
    } dump_state_t;

    // Header byte that marks the start of every dump on the UART stream
    localparam logic [7:0] LA_SYNC_BYTE = 8'hA5;

    // Number of bytes in one sample packet
    function automatic int packet_bytes(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/capture_dump_streamer_if.sv
// Capture-memory read port plus UART TX FIFO write port, as seen by the dumper.
interface capture_dump_streamer_if
    import la_pkg::*;
#(
    parameter int SAMPLE_PACKET_WIDTH = 32,
    parameter int ADDR_WIDTH          = 12
) ();
    logic                           mem_rd;
    logic [ADDR_WIDTH-1:0]          mem_addr;
    logic [SAMPLE_PACKET_WIDTH-1:0] mem_rdata;
    logic [7:0]                     utx_data;
    logic                           utx_buffer_write;
    logic                           utx_buffer_full;

    // The dumper drives reads and byte writes
    modport master (
        output mem_rd, mem_addr, utx_data, utx_buffer_write,
        input  mem_rdata, utx_buffer_full
    );

    // Memory / FIFO side
    modport slave (
        input  mem_rd, mem_addr, utx_data, utx_buffer_write,
        output mem_rdata, utx_buffer_full
    );
endinterface

// File: rtl/capture_dump_streamer.sv
// Reads a run of sample packets from capture memory and streams them,
// MSB byte first and preceded by a sync byte, into the UART TX FIFO.
// Every output is a register loaded with the value it must show in the
// next cycle, so a write strobe launched at an edge is only launched if
// the FIFO reported not-full at that edge.
module capture_dump_streamer
    import la_pkg::*;
#(
    parameter int         SAMPLE_PACKET_WIDTH = 32,
    parameter int         ADDR_WIDTH          = 12,
    parameter logic [7:0] SYNC_BYTE           = LA_SYNC_BYTE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   packet_count,
    output logic                  busy,
    output logic                  done,
    capture_dump_streamer_if.master dump_bus
);

    localparam int PB  = packet_bytes(SAMPLE_PACKET_WIDTH);
    localparam int BCW = $clog2(PB + 1);
    localparam int W   = SAMPLE_PACKET_WIDTH;

    localparam logic [BCW-1:0]        BC_FULL  = BCW'(PB);
    localparam logic [BCW-1:0]        BC_LAST  = BCW'(PB - 1);
    localparam logic [BCW-1:0]        BC_ONE   = BCW'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH + 1)'(1);

    dump_state_t           r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_rem;
    logic [BCW-1:0]        r_bcnt;   // bytes of the packet not yet put on the bus
    logic [W-1:0]          r_shift;
    logic                  r_mem_rd;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [7:0]            r_data;
    logic                  r_wr;
    logic                  r_busy;
    logic                  r_done;

    assign dump_bus.mem_rd           = r_mem_rd;
    assign dump_bus.mem_addr         = r_mem_addr;
    assign dump_bus.utx_data         = r_data;
    assign dump_bus.utx_buffer_write = r_wr;
    assign busy                      = r_busy;
    assign done                      = r_done;

    // Dump sequencer with its counters, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_rem      <= '0;
            r_bcnt     <= '0;
            r_shift    <= '0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_data     <= '0;
            r_wr       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-armed below
            r_mem_rd <= 1'b0;
            r_wr     <= 1'b0;
            r_done   <= 1'b0;

            if (r_state != ST_IDLE && abort) begin
                // Abort drops everything; no write or done is launched
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            r_addr  <= start_addr;
                            r_rem   <= packet_count;
                            r_state <= ST_HDR;
                            r_busy  <= 1'b1;
                            if (!dump_bus.utx_buffer_full) begin
                                r_data <= SYNC_BYTE;
                                r_wr   <= 1'b1;
                            end
                        end
                    end

                    ST_HDR: begin
                        if (r_wr) begin
                            // Sync byte is on the bus this cycle
                            if (r_rem == '0) begin
                                r_state <= ST_FIN;
                                r_done  <= 1'b1;
                            end else begin
                                r_state    <= ST_READ;
                                r_mem_rd   <= 1'b1;
                                r_mem_addr <= r_addr;
                            end
                        end else if (!dump_bus.utx_buffer_full) begin
                            r_data <= SYNC_BYTE;
                            r_wr   <= 1'b1;
                        end
                    end

                    ST_READ: begin
                        r_state <= ST_LOAD;
                    end

                    ST_LOAD: begin
                        // Read data is valid now; emit the first byte straight from it if possible
                        r_state <= ST_SEND;
                        if (!dump_bus.utx_buffer_full) begin
                            r_data  <= dump_bus.mem_rdata[W-1 -: 8];
                            r_shift <= dump_bus.mem_rdata << 8;
                            r_bcnt  <= BC_LAST;
                            r_wr    <= 1'b1;
                        end else begin
                            r_shift <= dump_bus.mem_rdata;
                            r_bcnt  <= BC_FULL;
                        end
                    end

                    ST_SEND: begin
                        if (r_wr && r_bcnt == '0) begin
                            // Last byte of the packet is being written this cycle
                            r_addr <= r_addr + ADDR_ONE;
                            r_rem  <= r_rem - REM_ONE;
                            if (r_rem == REM_ONE) begin
                                r_state <= ST_FIN;
                                r_done  <= 1'b1;
                            end else begin
                                r_state    <= ST_READ;
                                r_mem_rd   <= 1'b1;
                                r_mem_addr <= r_addr + ADDR_ONE;
                            end
                        end else if (!dump_bus.utx_buffer_full) begin
                            r_data  <= r_shift[W-1 -: 8];
                            r_shift <= r_shift << 8;
                            r_bcnt  <= r_bcnt - BC_ONE;
                            r_wr    <= 1'b1;
                        end
                    end

                    ST_FIN: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end

                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_capture_dump_streamer.sv
// Self-checking bench for capture_dump_streamer: table-driven dumps,
// hand-written corner sequences and randomized back-pressure runs.
module tb_capture_dump_streamer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [11:0] start_addr;
    logic [12:0] packet_count;
    logic        busy;
    logic        done;

    capture_dump_streamer_if #(.SAMPLE_PACKET_WIDTH(32), .ADDR_WIDTH(12)) bus ();

    capture_dump_streamer #(
        .SAMPLE_PACKET_WIDTH(32),
        .ADDR_WIDTH(12),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .start_addr(start_addr),
        .packet_count(packet_count),
        .busy(busy),
        .done(done),
        .dump_bus(bus.master)
    );

    always #5 clk = ~clk;

    // Capture memory model: synchronous read, data valid the cycle after mem_rd
    logic [31:0] mem [0:4095];
    always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Cycle bookkeeping: cycle 0 is the cycle in which start is driven
    int cyc = 0;
    int t0  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       mon_en = 1'b0;
    logic [7:0] wq[$];
    int         wc[$];
    logic [11:0] aq[$];
    int         ac[$];
    int         done_cnt, done_cyc, busy_off;
    logic       prev_full = 1'b0;
    logic [7:0] prev_data = 8'h00;

    // Observe the FIFO/memory side; also enforce back-pressure rules every cycle
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (bus.utx_buffer_write) begin
                wq.push_back(bus.utx_data);
                wc.push_back(cyc - t0);
            end
            if (bus.mem_rd) begin
                aq.push_back(bus.mem_addr);
                ac.push_back(cyc - t0);
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc - t0;
            end
            if (!busy && busy_off < 0 && cyc > t0) busy_off = cyc - t0;
            if (prev_full) begin
                chk("no_write_after_full", bus.utx_buffer_write, 0);
                chk("data_held_while_full", bus.utx_data, prev_data);
            end
        end
        prev_full = bus.utx_buffer_full;
        prev_data = bus.utx_data;
    end

    // Reference: the byte stream of a dump is the sync byte followed by
    // each packet of the address run (modulo memory size), MSB byte first
    function automatic logic [7:0] model_byte(input int a, input int i);
        int pkt, b;
        logic [31:0] w;
        if (i == 0) return 8'hA5;
        pkt = (i - 1) / 4;
        b   = (i - 1) % 4;
        w   = mem[(a + pkt) % 4096];
        return w[31 - 8*b -: 8];
    endfunction

    task automatic clear_mon();
        wq.delete(); wc.delete(); aq.delete(); ac.delete();
        done_cnt = 0; done_cyc = -1; busy_off = -1;
        t0 = cyc;
        mon_en = 1'b1;
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input int pct, input int limit);
        int k = 0;
        while (busy && k < limit) begin
            bus.utx_buffer_full = (pct > 0) && ($urandom_range(0, 99) < pct);
            @(posedge clk); #1;
            k++;
        end
        bus.utx_buffer_full = 1'b0;
        chk("dump_terminates", busy, 0);
        @(posedge clk); #1;
        mon_en = 1'b0;
    endtask

    task automatic run_dump(input logic [11:0] a, input logic [12:0] n, input int pct, input int limit);
        clear_mon();
        start_addr   = a;
        packet_count = n;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(pct, limit);
    endtask

    // Whole-dump checks against the reference model
    task automatic check_dump(input string nm, input int a, input int n);
        int nmis, amis, lim;
        chk({nm, "_write_count"}, wq.size(), 1 + 4*n);
        nmis = 0;
        lim = (wq.size() < 1 + 4*n) ? wq.size() : 1 + 4*n;
        for (int i = 0; i < lim; i++) if (wq[i] !== model_byte(a, i)) nmis++;
        chk({nm, "_stream_mismatches"}, nmis, 0);
        chk({nm, "_read_count"}, aq.size(), n);
        amis = 0;
        lim = (aq.size() < n) ? aq.size() : n;
        for (int i = 0; i < lim; i++) if (aq[i] !== 12'((a + i) % 4096)) amis++;
        chk({nm, "_addr_mismatches"}, amis, 0);
        chk({nm, "_done_pulses"}, done_cnt, 1);
        if (wc.size() > 0) chk({nm, "_done_after_last_write"}, done_cyc, wc[wc.size()-1] + 1);
        chk({nm, "_busy_drop"}, busy_off, done_cyc + 1);
    endtask

    typedef struct {
        logic [11:0] addr;
        logic [12:0] cnt;
        int          exp_done;
        int          exp_writes;
        int          rd0;
        int          rd1;
    } vec_t;

    vec_t vt[5];
    logic [7:0] basic_bytes[9];
    int bp_cycles[5];

    initial begin
        vt[0] = '{12'h010, 13'd2, 14,  9, 'h010, 'h011};
        vt[1] = '{12'hFFF, 13'd2, 14,  9, 'hFFF, 'h000};
        vt[2] = '{12'h100, 13'd0,  2,  1,    -1,    -1};
        vt[3] = '{12'h200, 13'd1,  8,  5, 'h200,    -1};
        vt[4] = '{12'h7FE, 13'd3, 20, 13, 'h7FE, 'h7FF};
        basic_bytes = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        bp_cycles   = '{1, 4, 10, 11, 12};

        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        mem[12'h010] = 32'h11223344;
        mem[12'h011] = 32'h55667788;
        mem[12'h020] = 32'hCAFEBABE;

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        start_addr = '0; packet_count = '0;
        bus.utx_buffer_full = 1'b0;
        step(3);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_utx_data", bus.utx_data, 0);
        chk("rst_utx_write", bus.utx_buffer_write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        step(2);

        // Table of unstalled dumps with hand-derived timing
        for (int v = 0; v < 5; v++) begin
            run_dump(vt[v].addr, vt[v].cnt, 0, 500);
            check_dump($sformatf("vec%0d", v), int'(vt[v].addr), int'(vt[v].cnt));
            chk($sformatf("vec%0d_writes", v), wq.size(), vt[v].exp_writes);
            chk($sformatf("vec%0d_done_cycle", v), done_cyc, vt[v].exp_done);
            if (wc.size() > 0) chk($sformatf("vec%0d_sync_cycle", v), wc[0], 1);
            if (vt[v].rd0 >= 0 && aq.size() > 0) begin
                chk($sformatf("vec%0d_rd0_addr", v), aq[0], vt[v].rd0);
                chk($sformatf("vec%0d_rd0_cycle", v), ac[0], 2);
                if (wc.size() > 1) chk($sformatf("vec%0d_first_data_cycle", v), wc[1], 4);
            end
            if (vt[v].rd1 >= 0 && aq.size() > 1) chk($sformatf("vec%0d_rd1_addr", v), aq[1], vt[v].rd1);
            if (v == 0) begin
                for (int i = 0; i < 9 && i < wq.size(); i++)
                    chk($sformatf("basic_byte%0d", i), wq[i], basic_bytes[i]);
            end
        end

        // Back-pressure: FIFO full for 5 cycles while the 2nd data byte is due;
        // a second start during the dump must be ignored
        clear_mon();
        start_addr = 12'h020; packet_count = 13'd1; start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        start = 1'b1; start_addr = 12'h555; packet_count = 13'd3;
        step(1);
        start = 1'b0;
        step(1);
        bus.utx_buffer_full = 1'b1;
        step(5);
        bus.utx_buffer_full = 1'b0;
        wait_idle(0, 200);
        check_dump("bp", 'h020, 1);
        for (int i = 0; i < 5 && i < wc.size(); i++)
            chk($sformatf("bp_write_cycle%0d", i), wc[i], bp_cycles[i]);
        chk("bp_done_cycle", done_cyc, 13);

        // Abort while the 3rd data byte is on the bus
        clear_mon();
        start_addr = 12'h030; packet_count = 13'd2; start = 1'b1;
        step(1);
        start = 1'b0;
        step(5);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("abort_busy_low", busy, 0);
        chk("abort_no_write", bus.utx_buffer_write, 0);
        step(10);
        chk("abort_write_count", wq.size(), 4);
        for (int i = 0; i < 4 && i < wq.size(); i++)
            chk($sformatf("abort_prefix%0d", i), wq[i], model_byte('h030, i));
        chk("abort_no_done", done_cnt, 0);
        mon_en = 1'b0;

        // start and abort together while idle: nothing happens
        clear_mon();
        start_addr = 12'h040; packet_count = 13'd1; start = 1'b1; abort = 1'b1;
        step(1);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        step(6);
        chk("start_abort_writes", wq.size(), 0);
        chk("start_abort_reads", aq.size(), 0);
        mon_en = 1'b0;

        // Reset in the middle of SEND, then a clean dump
        clear_mon();
        start_addr = 12'h044; packet_count = 13'd2; start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        reset = 1'b1;
        step(1);
        chk("midrst_mem_rd", bus.mem_rd, 0);
        chk("midrst_mem_addr", bus.mem_addr, 0);
        chk("midrst_utx_data", bus.utx_data, 0);
        chk("midrst_utx_write", bus.utx_buffer_write, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        reset = 1'b0;
        mon_en = 1'b0;
        step(1);
        run_dump(12'h050, 13'd1, 0, 200);
        check_dump("post_rst", 'h050, 1);
        if (wq.size() > 0) chk("post_rst_sync", wq[0], 8'hA5);
        chk("post_rst_done_cycle", done_cyc, 8);

        // Randomized dumps with random FIFO back-pressure
        for (int r = 0; r < 8; r++) begin
            int a, n;
            a = $urandom_range(0, 4095);
            n = $urandom_range(0, 6);
            run_dump(12'(a), 13'(n), 35, 2000);
            check_dump($sformatf("rand%0d", r), a, n);
        end

        // More packets than the address space: addresses wrap and repeat
        run_dump(12'hFFE, 13'd4097, 0, 30000);
        check_dump("long", 'hFFE, 4097);
        chk("long_done_cycle", done_cyc, 2 + 6*4097);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
